// File: rtl/alu_issue_ctrl_if.sv
// Decode-to-ALU-to-writeback bundle: request handshake, registered ALU inputs,
// ALU result/flags, response handshake and the architectural flag register.
interface alu_issue_ctrl_if;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b, req_shamt, req_offset;
    logic [1:0]  req_src;
    logic [2:0]  req_op;
    logic        req_setf;
    logic [31:0] alu_a, alu_b, alu_shamt, alu_offset;
    logic [1:0]  alu_source;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_carry, alu_zero, alu_sign;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carry, rsp_zero, rsp_sign;
    logic        flag_carry, flag_zero, flag_sign;

    modport slave (
        input  req_valid, req_a, req_b, req_shamt, req_offset, req_src, req_op, req_setf,
               alu_result, alu_carry, alu_zero, alu_sign, rsp_ready,
        output req_ready, alu_a, alu_b, alu_shamt, alu_offset, alu_source, alu_op,
               rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign,
               flag_carry, flag_zero, flag_sign
    );

    modport master (
        output req_valid, req_a, req_b, req_shamt, req_offset, req_src, req_op, req_setf,
               alu_result, alu_carry, alu_zero, alu_sign, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_shamt, alu_offset, alu_source, alu_op,
               rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign,
               flag_carry, flag_zero, flag_sign
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller on the ALU operand side: registers one op, holds it
// for SETTLE_CYCLES, captures result/flags and hands them off via valid/ready.
module alu_issue_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       setf;
    logic       accept, capture, ready_c, valid_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // RESP re-arms combinationally from rsp_ready so a new op can issue on the
    // same edge as the response handshake.
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        valid_c   = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    ready_c = 1'b1;
                    if (bus.req_valid) begin
                        accept    = 1'b1;
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = valid_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_shamt  <= '0;
            bus.alu_offset <= '0;
            bus.alu_source <= '0;
            bus.alu_op     <= '0;
            setf           <= 1'b0;
            cnt            <= '0;
        end else if (accept) begin
            bus.alu_a      <= bus.req_a;
            bus.alu_b      <= bus.req_b;
            bus.alu_shamt  <= bus.req_shamt;
            bus.alu_offset <= bus.req_offset;
            bus.alu_source <= bus.req_src;
            bus.alu_op     <= bus.req_op;
            setf           <= bus.req_setf;
            cnt            <= CNT_LOAD;
        end else if (state == SETTLE && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_sign   <= 1'b0;
            bus.flag_carry <= 1'b0;
            bus.flag_zero  <= 1'b0;
            bus.flag_sign  <= 1'b0;
        end else if (capture) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_carry  <= bus.alu_carry;
            bus.rsp_zero   <= bus.alu_zero;
            bus.rsp_sign   <= bus.alu_sign;
            if (setf) begin
                bus.flag_carry <= bus.alu_carry;
                bus.flag_zero  <= bus.alu_zero;
                bus.flag_sign  <= bus.alu_sign;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (settle 1 and 3) behind a small ALU
// model; directed vector table, hand sequences, then random vs a timing model.
module tb_alu_issue_ctrl;
    localparam int unsigned SC_A = 1;
    localparam int unsigned SC_B = 3;

    if (SC_A < 1 || SC_A > 15 || SC_B < 1 || SC_B > 15) begin : g_cfg_err
        $error("SETTLE_CYCLES outside 1..15");
    end

    typedef struct packed {
        logic c, z, s;
        logic [31:0] r;
    } alu_o_t;

    typedef struct packed {
        logic        rdy, vld;
        logic [31:0] res;
        logic        rc, rz, rs, fc, fz, fs;
        logic [31:0] a, b, sh, off;
        logic [1:0]  src;
        logic [2:0]  op;
    } obs_t;

    typedef struct {
        logic [31:0] a, b, sh, off;
        logic [1:0]  src;
        logic [2:0]  op;
        logic        setf;
        logic [31:0] er;
        logic        ec, ez, es;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rv, rr;
    logic [31:0] a, b, sh, off, tog;
    logic [1:0]  src;
    logic [2:0]  op;
    logic        setf;
    obs_t        obs [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    vec_t        vt [6];
    logic [2:0]  ef;
    int          lat, r1, r2, cyc;
    logic        prev;
    logic [1:0]  ev, acc, hs;
    alu_o_t      nres;
    logic        m_busy [2];
    int          m_at [2];
    alu_o_t      m_res [2], m_rsp [2];
    logic        m_setf [2];
    logic [2:0]  m_fl [2];
    logic [31:0] m_a [2];
    logic [4:0]  m_code [2];

    always #5 clk = ~clk;

    // Reference ALU: the second operand is picked by src, op selects the function.
    function automatic alu_o_t alu_f(input logic [31:0] x, y_b, y_sh, y_off,
                                     input logic [1:0] s, input logic [2:0] o);
        logic [31:0] y;
        logic [32:0] sum;
        alu_o_t      q;
        case (s)
            2'b00:   y = y_b;
            2'b01:   y = y_off;
            2'b10:   y = y_sh;
            default: y = ~y_b;
        endcase
        q.c = 1'b0;
        case (o)
            3'b000: begin sum = {1'b0, x} + {1'b0, y}; q.r = sum[31:0]; q.c = sum[32]; end
            3'b001: q.r = x - y;
            3'b010: q.r = x & y;
            3'b011: q.r = x | y;
            3'b100: q.r = x ^ y;
            3'b101: q.r = x << y[4:0];
            3'b110: q.r = x >> y[4:0];
            default: q.r = y;
        endcase
        q.z = (q.r == 32'd0);
        q.s = q.r[31];
        return q;
    endfunction

    alu_issue_ctrl_if bus [2] ();

    for (genvar k = 0; k < 2; k++) begin : g_dut
        alu_o_t f;
        alu_issue_ctrl #(.SETTLE_CYCLES(k == 0 ? SC_A : SC_B)) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus[k])
        );
        assign bus[k].req_valid  = rv[k];
        assign bus[k].rsp_ready  = rr[k];
        assign bus[k].req_a      = a;
        assign bus[k].req_b      = b;
        assign bus[k].req_shamt  = sh;
        assign bus[k].req_offset = off;
        assign bus[k].req_src    = src;
        assign bus[k].req_op     = op;
        assign bus[k].req_setf   = setf;
        assign f = alu_f(bus[k].alu_a, bus[k].alu_b, bus[k].alu_shamt, bus[k].alu_offset,
                         bus[k].alu_source, bus[k].alu_op);
        assign bus[k].alu_result = f.r ^ tog;
        assign bus[k].alu_carry  = f.c;
        assign bus[k].alu_zero   = f.z;
        assign bus[k].alu_sign   = f.s;
        assign obs[k] = '{rdy: bus[k].req_ready, vld: bus[k].rsp_valid, res: bus[k].rsp_result,
                          rc: bus[k].rsp_carry, rz: bus[k].rsp_zero, rs: bus[k].rsp_sign,
                          fc: bus[k].flag_carry, fz: bus[k].flag_zero, fs: bus[k].flag_sign,
                          a: bus[k].alu_a, b: bus[k].alu_b, sh: bus[k].alu_shamt,
                          off: bus[k].alu_offset, src: bus[k].alu_source, op: bus[k].alu_op};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sc(input int k);
        return (k == 0) ? int'(SC_A) : int'(SC_B);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'd32, 32'd16, 32'd2, 32'd10, 2'b00, 3'b000, 1'b1, 32'd48, 1'b0, 1'b0, 1'b0};
        vt[1] = '{32'd5, 32'd5, 32'd0, 32'd0, 2'b00, 3'b001, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0};
        vt[2] = '{32'd5, 32'd5, 32'd0, 32'd0, 2'b00, 3'b001, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 2'b00, 3'b000, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0};
        vt[4] = '{32'd1, 32'd0, 32'd31, 32'd0, 2'b10, 3'b101, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vt[5] = '{32'h0F0F_0000, 32'd0, 32'd0, 32'h00FF_00FF, 2'b01, 3'b011, 1'b0,
                  32'h0FFF_00FF, 1'b0, 1'b0, 1'b0};

        rv = '0; rr = '0; a = '0; b = '0; sh = '0; off = '0; src = '0; op = '0;
        setf = 1'b0; tog = '0;

        // reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", 32'(obs[k].rdy), 32'd1);
            chk("rst_rsp_valid", 32'(obs[k].vld), 32'd0);
            chk("rst_alu", obs[k].a | obs[k].b | obs[k].sh | obs[k].off | 32'({obs[k].src, obs[k].op}), 32'd0);
            chk("rst_rsp", obs[k].res | 32'({obs[k].rc, obs[k].rz, obs[k].rs}), 32'd0);
            chk("rst_flags", 32'({obs[k].fc, obs[k].fz, obs[k].fs}), 32'd0);
        end
        rst_n = 1'b1;

        // vector table on the settle-1 instance, with backpressure after the first op
        ef = 3'b000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = vt[i].a; b = vt[i].b; sh = vt[i].sh; off = vt[i].off;
            src = vt[i].src; op = vt[i].op; setf = vt[i].setf;
            rv[0] = 1'b1; rr[0] = 1'b0;
            #1 chk("tbl_req_ready", 32'(obs[0].rdy), 32'd1);
            @(posedge clk);
            #1 rv[0] = 1'b0;
            @(negedge clk);
            chk("tbl_alu_a", obs[0].a, vt[i].a);
            chk("tbl_alu_b", obs[0].b, vt[i].b);
            chk("tbl_alu_shamt", obs[0].sh, vt[i].sh);
            chk("tbl_alu_offset", obs[0].off, vt[i].off);
            chk("tbl_alu_code", 32'({obs[0].src, obs[0].op}), 32'({vt[i].src, vt[i].op}));
            chk("tbl_early_valid", 32'(obs[0].vld), 32'd0);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!obs[0].vld && lat < 20);
            chk("tbl_latency", 32'(lat), 32'(SC_A));
            chk("tbl_result", obs[0].res, vt[i].er);
            chk("tbl_rsp_flags", 32'({obs[0].rc, obs[0].rz, obs[0].rs}),
                32'({vt[i].ec, vt[i].ez, vt[i].es}));
            if (vt[i].setf) ef = {vt[i].ec, vt[i].ez, vt[i].es};
            chk("tbl_arch_flags", 32'({obs[0].fc, obs[0].fz, obs[0].fs}), 32'(ef));
            if (i == 0) begin
                for (int j = 0; j < 5; j++) begin
                    tog = $urandom | 32'd1;
                    @(negedge clk);
                    chk("bp_result", obs[0].res, vt[0].er);
                    chk("bp_valid", 32'(obs[0].vld), 32'd1);
                    chk("bp_req_ready", 32'(obs[0].rdy), 32'd0);
                end
                tog = '0;
            end
            rr[0] = 1'b1;
            @(posedge clk);
            #1 rr[0] = 1'b0;
            @(negedge clk);
            chk("tbl_done_valid", 32'(obs[0].vld), 32'd0);
            chk("tbl_done_ready", 32'(obs[0].rdy), 32'd1);
        end

        // back-to-back issue on the settle-3 instance
        @(negedge clk);
        a = 32'd7; b = 32'd9; sh = 32'd4; off = 32'd0; src = 2'b10; op = 3'b000; setf = 1'b1;
        rv[1] = 1'b1; rr[1] = 1'b1;
        @(posedge clk);
        #1 a = 32'd3; b = 32'h8000_1234; src = 2'b00; op = 3'b111;
        prev = 1'b0; r1 = 0; r2 = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (obs[1].vld && !prev) begin
                if (r1 == 0) r1 = c;
                else         r2 = c;
            end
            prev = obs[1].vld;
            if (c <= int'(SC_B) + 1) chk("b2b_code1", 32'({obs[1].src, obs[1].op}), 32'b10000);
            else                     chk("b2b_code2", 32'({obs[1].src, obs[1].op}), 32'b00111);
            if (c == 2) chk("b2b_settle_ready", 32'(obs[1].rdy), 32'd0);
            if (c == int'(SC_B) + 1) begin
                chk("b2b_result1", obs[1].res, 32'd11);
                chk("b2b_coincident_ready", 32'(obs[1].rdy), 32'd1);
            end
            if (c == 2 * int'(SC_B) + 2) begin
                chk("b2b_result2", obs[1].res, 32'h8000_1234);
                chk("b2b_flag_sign", 32'(obs[1].fs), 32'd1);
                rv[1] = 1'b0;
            end
        end
        chk("b2b_rise1", 32'(r1), 32'(SC_B + 1));
        chk("b2b_gap", 32'(r2 - r1), 32'(SC_B + 1));

        // asynchronous reset while settling
        @(negedge clk);
        a = 32'd1; b = 32'd1; src = 2'b00; op = 3'b001; setf = 1'b1; rv[1] = 1'b1; rr[1] = 1'b0;
        @(posedge clk);
        #1 rv[1] = 1'b0;
        @(negedge clk);
        chk("mid_settle_valid", 32'(obs[1].vld), 32'd0);
        chk("mid_flag_sign_before", 32'(obs[1].fs), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(obs[1].rdy), 32'd1);
        chk("mid_rst_valid", 32'(obs[1].vld), 32'd0);
        chk("mid_rst_flags", 32'({obs[1].fc, obs[1].fz, obs[1].fs}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(obs[1].vld), 32'd0);
            chk("post_rst_flags", 32'({obs[1].fc, obs[1].fz, obs[1].fs}), 32'd0);
        end

        // random traffic against a transaction-timing model
        rst_n = 1'b0; rv = '0; rr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_at[k] = 0; m_res[k] = '0; m_rsp[k] = '0;
            m_setf[k] = 1'b0; m_fl[k] = 3'b000; m_a[k] = '0; m_code[k] = '0;
        end
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ev[k] = m_busy[k] && (cyc >= m_at[k]);
                chk("rnd_rsp_valid", 32'(obs[k].vld), 32'(ev[k]));
                chk("rnd_rsp_result", obs[k].res, m_rsp[k].r);
                chk("rnd_rsp_flags", 32'({obs[k].rc, obs[k].rz, obs[k].rs}),
                    32'({m_rsp[k].c, m_rsp[k].z, m_rsp[k].s}));
                chk("rnd_arch_flags", 32'({obs[k].fc, obs[k].fz, obs[k].fs}), 32'(m_fl[k]));
                chk("rnd_alu_a", obs[k].a, m_a[k]);
                chk("rnd_alu_code", 32'({obs[k].src, obs[k].op}), 32'(m_code[k]));
            end
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            sh = $urandom; off = $urandom;
            src = 2'($urandom); op = 3'($urandom); setf = 1'($urandom);
            rv = 2'($urandom); rr = 2'($urandom);
            nres = alu_f(a, b, sh, off, src, op);
            #1;
            for (int k = 0; k < 2; k++) begin
                chk("rnd_req_ready", 32'(obs[k].rdy), 32'(!m_busy[k] || (ev[k] && rr[k])));
                acc[k] = rv[k] && (!m_busy[k] || (ev[k] && rr[k]));
                hs[k]  = ev[k] && rr[k];
            end
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (hs[k]) m_busy[k] = 1'b0;
                if (acc[k]) begin
                    m_busy[k] = 1'b1;
                    m_at[k]   = cyc + sc(k);
                    m_res[k]  = nres;
                    m_setf[k] = setf;
                    m_a[k]    = a;
                    m_code[k] = {src, op};
                end
                if (m_busy[k] && cyc == m_at[k]) begin
                    m_rsp[k] = m_res[k];
                    if (m_setf[k]) m_fl[k] = {m_res[k].c, m_res[k].z, m_res[k].s};
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/capture controller on the operand side of the KGP_RISC ALU. It accepts one operation per handshake from decode and registers the operands, shift amount, offset, ALUsource and ALUop onto the ALU inputs. It holds them for a programmable settle window, captures result and carry/zero/sign, and presents them to writeback/branch logic through a valid/ready handshake. It also keeps an architectural flag register for later conditional branches.

## Interface
- SETTLE_CYCLES, 1: cycles the ALU inputs are held stable before capture; legal range 1..15.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  decode presents an operation.
- req_ready  out  1  controller can accept an operation.
- req_a, req_b  in  32 each  operands.
- req_shamt  in  32  shift amount.
- req_offset  in  32  immediate/offset.
- req_src  in  2  ALUsource code, passed through unchanged.
- req_op  in  3  ALUop code, passed through unchanged.
- req_setf  in  1  update the flag register on capture.
- alu_a, alu_b, alu_shamt, alu_offset  out  32 each  registered ALU inputs.
- alu_source  out  2  registered ALUsource.
- alu_op  out  3  registered ALUop.
- alu_result  in  32  ALU result.
- alu_carry, alu_zero, alu_sign  in  1 each  ALU flags.
- rsp_valid  out  1  captured result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_result  out  32  captured result.
- rsp_carry, rsp_zero, rsp_sign  out  1 each  captured flags.
- flag_carry, flag_zero, flag_sign  out  1 each  architectural flag register.

## Operation
- States: IDLE, SETTLE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, load all req_* fields into the alu_* registers and a setf register. Load settle counter with SETTLE_CYCLES-1. Go to SETTLE.
- SETTLE: req_ready=0. alu_* stay constant. If counter≠0, decrement it. If counter=0, capture alu_result and the three flags into the rsp_* registers, update flag_* from the ALU flags when setf=1, and go to RESP.
- RESP: rsp_valid=1. rsp_* stay constant until rsp_valid&rsp_ready.
  - Handshake done and req_valid=1: req_ready=1 in this same cycle (combinational from rsp_ready). The new request is loaded and the state goes to SETTLE, giving back-to-back issue.
  - Handshake done, no request: go to IDLE.
  - rsp_ready=0: req_ready=0.
- alu_* keep their last value in IDLE and RESP. They are not cleared after completion.
- Codes are passed through opaquely. The controller never interprets req_src or req_op.
- The counter is 4 bits wide. SETTLE_CYCLES outside 1..15 is a configuration error; the bench checks it with an elaboration-time assertion.

## Timing
- Reset (async assert, clocked release): state IDLE. req_ready=1, rsp_valid=0. All alu_*, rsp_* and flag_* are 0 (alu_source=2'b00, alu_op=3'b000).
- Accept at edge T. alu_* are valid after T. Capture happens at edge T+SETTLE_CYCLES. rsp_valid is high after that edge.
- Latency from accept to rsp_valid is SETTLE_CYCLES cycles. Back-to-back throughput is one op per SETTLE_CYCLES+1 cycles when rsp_ready is held high.
- flag_* change only at the capture edge and only when setf=1. rsp_* change only at the capture edge.
- rsp_valid must not drop without a handshake. rsp_* must not change while rsp_valid=1 and rsp_ready=0.
- req_valid during SETTLE is ignored (req_ready=0). The requester must hold it.
- Reset mid-SETTLE or mid-RESP: the pending operation is discarded. No response is produced and flags read 0.
- rsp_ready high in IDLE or SETTLE has no effect.

## Test plan
- Reset, then check idle values: hold rst_n=0 for 3 cycles -> req_ready=1, rsp_valid=0, and all alu_*, rsp_*, flag_* are 0.
- Single op at SETTLE_CYCLES=1, with the bench ALU model returning a+b for src 00/op 000:
  - stimulus: a=32, b=16, shamt=2, offset=10, src=00, op=000, setf=1
  - response: alu_* show those values one cycle after accept, rsp_valid rises one cycle later with rsp_result=48, and flag_zero=0.
- Backpressure:
  - stimulus: hold rsp_ready=0 for 5 cycles after rsp_valid, while toggling the model's alu_result
  - response: rsp_result stays 48, and req_ready=0 throughout.
- Back-to-back issue:
  - stimulus: src=10/op 000, then src=00/op 111 presented with rsp_ready=1 at SETTLE_CYCLES=3
  - response: the second accept coincides with the first response handshake, there are 4 cycles between the two rsp_valid rises, and alu_source/alu_op go 2'b10/3'b000 then 2'b00/3'b111.
- setf gating:
  - stimulus: an op whose model asserts zero with setf=0, then one with setf=1
  - response: flag_zero stays 0 after the first op and is 1 after the second, while rsp_zero=1 both times.
- Reset mid-operation: assert rst_n=0 asynchronously during SETTLE -> state IDLE immediately, no rsp_valid pulse, flags 0.
